// File: rtl/i2s_codec_slave_if.sv
// Serial link pins and parallel sample bus between an I2S master and i2s_codec_slave.
// The master modport is the codec_interface/bench side. The slave modport is the codec side.
interface i2s_codec_slave_if #(
  parameter int DATA_W = 16
);
  logic              SCLK;
  logic              LRCLK;
  logic              SDin;
  logic              SDout;
  logic [DATA_W-1:0] adc_lft;
  logic [DATA_W-1:0] adc_rht;
  logic              adc_ld;
  logic [DATA_W-1:0] dac_lft;
  logic [DATA_W-1:0] dac_rht;
  logic              dac_vld;
  logic              frame_err;

  modport master (
    output SCLK, LRCLK, SDin, adc_lft, adc_rht,
    input  SDout, adc_ld, dac_lft, dac_rht, dac_vld, frame_err
  );

  modport slave (
    input  SCLK, LRCLK, SDin, adc_lft, adc_rht,
    output SDout, adc_ld, dac_lft, dac_rht, dac_vld, frame_err
  );
endinterface

// File: rtl/i2s_codec_slave.sv
// Codec-side I2S serial port. SCLK/LRCLK/SDin are oversampled on clk; SDin is deserialized into dac pairs; adc pairs are serialized onto SDout.
// Optional macro LEFT_JUSTIFIED_EN selects left-justified framing instead of the standard I2S 1-bit delay.
module i2s_codec_slave #(
  parameter int DATA_W   = 16,
  parameter int SLOT_MAX = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  i2s_codec_slave_if.slave bus
);

  localparam logic [0:0] ST_SYNC = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int               CNT_W    = $clog2(SLOT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_WORD = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
`ifdef LEFT_JUSTIFIED_EN
  // The boundary rise already carries the MSB, so every rise of the slot is counted.
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(SLOT_MAX);
`else
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(SLOT_MAX - 1);
`endif

  logic [2:0]        pin_meta_reg, pin_sync_reg;
  logic              sclk_prev_reg, lr_prev_reg;
  logic [0:0]        state_reg;
  logic              ch_reg, left_done_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] rx_shift_reg, lft_hold_reg, tx_shift_reg, adc_rht_lat_reg;
  logic [DATA_W-1:0] dac_lft_reg, dac_rht_reg;
  logic              sdout_reg, dac_vld_reg, adc_ld_reg, frame_err_reg;

  logic              sclk_s, lr_s, sd_s, sclk_rise, sclk_fall, boundary, short_slot;
  logic [DATA_W-1:0] rx_next, tx_load;

  assign sclk_s     = pin_sync_reg[0];
  assign lr_s       = pin_sync_reg[1];
  assign sd_s       = pin_sync_reg[2];
  assign sclk_rise  = sclk_s & ~sclk_prev_reg;
  assign sclk_fall  = ~sclk_s & sclk_prev_reg;
  assign boundary   = sclk_rise & (lr_s ^ lr_prev_reg);
  assign short_slot = (state_reg == ST_RUN) && (cnt_reg < CNT_WORD);
  assign rx_next    = {rx_shift_reg[DATA_W-2:0], sd_s};
  assign tx_load    = lr_s ? adc_rht_lat_reg : bus.adc_lft;

  assign bus.SDout     = sdout_reg;
  assign bus.dac_lft   = dac_lft_reg;
  assign bus.dac_rht   = dac_rht_reg;
  assign bus.dac_vld   = dac_vld_reg;
  assign bus.adc_ld    = adc_ld_reg;
  assign bus.frame_err = frame_err_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pin_meta_reg    <= '0;
      pin_sync_reg    <= '0;
      sclk_prev_reg   <= 1'b0;
      lr_prev_reg     <= 1'b0;
      state_reg       <= ST_SYNC;
      ch_reg          <= 1'b0;
      left_done_reg   <= 1'b0;
      cnt_reg         <= '0;
      rx_shift_reg    <= '0;
      lft_hold_reg    <= '0;
      tx_shift_reg    <= '0;
      adc_rht_lat_reg <= '0;
      dac_lft_reg     <= '0;
      dac_rht_reg     <= '0;
      sdout_reg       <= 1'b0;
      dac_vld_reg     <= 1'b0;
      adc_ld_reg      <= 1'b0;
      frame_err_reg   <= 1'b0;
    end else begin
      pin_meta_reg  <= {bus.SDin, bus.LRCLK, bus.SCLK};
      pin_sync_reg  <= pin_meta_reg;
      sclk_prev_reg <= sclk_s;
      dac_vld_reg   <= 1'b0;
      adc_ld_reg    <= 1'b0;

      if (sclk_fall) begin
        sdout_reg    <= tx_shift_reg[DATA_W-1];
        tx_shift_reg <= {tx_shift_reg[DATA_W-2:0], 1'b0};
      end

      if (sclk_rise) begin
        lr_prev_reg <= lr_s;
        if (boundary && short_slot) begin
          frame_err_reg <= 1'b1;
          state_reg     <= ST_SYNC;
          left_done_reg <= 1'b0;
          cnt_reg       <= '0;
          tx_shift_reg  <= '0;
        end else if (boundary && (state_reg == ST_RUN || !lr_s)) begin
          // Out of SYNC only a left boundary locks, so a frame always starts on the left word.
          state_reg <= ST_RUN;
          ch_reg    <= lr_s;
          if (!lr_s) begin
            adc_rht_lat_reg <= bus.adc_rht;
            adc_ld_reg      <= 1'b1;
            left_done_reg   <= 1'b0;
          end
`ifdef LEFT_JUSTIFIED_EN
          rx_shift_reg <= rx_next;
          cnt_reg      <= CNT_W'(1);
          sdout_reg    <= tx_load[DATA_W-1];
          tx_shift_reg <= {tx_load[DATA_W-2:0], 1'b0};
`else
          cnt_reg      <= '0;
          tx_shift_reg <= tx_load;
`endif
        end else if (!boundary && state_reg == ST_RUN) begin
          if (cnt_reg >= CNT_LIMIT) begin
            frame_err_reg <= 1'b1;
            state_reg     <= ST_SYNC;
            left_done_reg <= 1'b0;
            cnt_reg       <= '0;
            tx_shift_reg  <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg < CNT_WORD) begin
              rx_shift_reg <= rx_next;
              if (cnt_reg == CNT_LAST) begin
                if (!ch_reg) begin
                  lft_hold_reg  <= rx_next;
                  left_done_reg <= 1'b1;
                end else if (left_done_reg) begin
                  dac_lft_reg   <= lft_hold_reg;
                  dac_rht_reg   <= rx_next;
                  dac_vld_reg   <= 1'b1;
                  left_done_reg <= 1'b0;
                end
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_codec_slave.sv
// Directed bench for i2s_codec_slave (default I2S framing): acts as the I2S master with SCLK half-period of 5 clk.
module tb_i2s_codec_slave;
  localparam int DATA_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2s_codec_slave_if #(.DATA_W(DATA_W)) bus ();

  i2s_codec_slave #(.DATA_W(DATA_W), .SLOT_MAX(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int vld_cnt = 0;
  int ld_cnt = 0;
  logic sd_obs;

  always @(negedge clk) begin
    if (bus.dac_vld === 1'b1) vld_cnt++;
    if (bus.adc_ld === 1'b1) ld_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One SCLK period: LRCLK changes with the fall, SDout is sampled just before the rise.
  task automatic send_bit(input logic lr, input logic d, input logic loop);
    bus.SCLK  = 1'b0;
    bus.LRCLK = lr;
    #40;
    sd_obs   = bus.SDout;
    bus.SDin = loop ? sd_obs : d;
    #10;
    bus.SCLK = 1'b1;
    #50;
  endtask

  task automatic send_slot(input logic lr, input logic [DATA_W-1:0] word, input int nrises,
                           input logic loop, output logic [DATA_W-1:0] txw, output int tail);
    logic d;
    txw  = '0;
    tail = 0;
    for (int k = 0; k < nrises; k++) begin
      d = (k >= 1 && k <= DATA_W) ? word[DATA_W-k] : 1'b0;
      send_bit(lr, d, loop);
      if (k >= 1 && k <= DATA_W) txw[DATA_W-k] = sd_obs;
      else if (sd_obs) tail++;
    end
  endtask

  initial begin
    logic [DATA_W-1:0] txl, txr;
    int tl, tr, vbase, lbase;

    bus.SCLK = 1'b0; bus.LRCLK = 1'b0; bus.SDin = 1'b0;
    bus.adc_lft = '0; bus.adc_rht = '0;
    #100;
    check("rst_sdout", 32'(bus.SDout), 0);
    check("rst_dac_lft", 32'(bus.dac_lft), 0);
    check("rst_dac_rht", 32'(bus.dac_rht), 0);
    check("rst_pulses", 32'({bus.dac_vld, bus.adc_ld}), 0);
    check("rst_frame_err", 32'(bus.frame_err), 0);
    rst_n = 1'b1;
    #100;

    // Warm-up frame: no left boundary is seen yet, so nothing is emitted.
    send_slot(1'b0, 16'hFFFF, 32, 1'b0, txl, tl);
    send_slot(1'b1, 16'hFFFF, 32, 1'b0, txr, tr);
    check("warm_vld_cnt", 32'(vld_cnt), 0);
    check("warm_ld_cnt", 32'(ld_cnt), 0);

    // Receive and transmit on the first locked frame.
    bus.adc_lft = 16'h8001; bus.adc_rht = 16'h7FFE;
    send_slot(1'b0, 16'hA5C3, 32, 1'b0, txl, tl);
    send_slot(1'b1, 16'h1234, 32, 1'b0, txr, tr);
    check("rx_dac_lft", 32'(bus.dac_lft), 32'hA5C3);
    check("rx_dac_rht", 32'(bus.dac_rht), 32'h1234);
    check("rx_vld_cnt", 32'(vld_cnt), 1);
    check("tx_ld_cnt", 32'(ld_cnt), 1);
    check("tx_left", 32'(txl), 32'h8001);
    check("tx_right", 32'(txr), 32'h7FFE);
    check("tx_left_tail", 32'(tl), 0);
    check("tx_right_tail", 32'(tr), 0);

    // Loopback with ramp samples 0..9.
    for (int i = 0; i < 5; i++) begin
      vbase = vld_cnt;
      bus.adc_lft = 16'(2 * i);
      bus.adc_rht = 16'(2 * i + 1);
      send_slot(1'b0, 16'h0000, 32, 1'b1, txl, tl);
      send_slot(1'b1, 16'h0000, 32, 1'b1, txr, tr);
      check("loop_dac_lft", 32'(bus.dac_lft), 32'(2 * i));
      check("loop_dac_rht", 32'(bus.dac_rht), 32'(2 * i + 1));
      check("loop_vld", 32'(vld_cnt - vbase), 1);
    end
    check("loop_frame_err", 32'(bus.frame_err), 0);

    // Minimum legal slot: boundary plus exactly DATA_W bits.
    vbase = vld_cnt;
    send_slot(1'b0, 16'h1357, 17, 1'b0, txl, tl);
    send_slot(1'b1, 16'h9BDF, 17, 1'b0, txr, tr);
    send_slot(1'b0, 16'h0000, 32, 1'b0, txl, tl);
    check("min_slot_dac_lft", 32'(bus.dac_lft), 32'h1357);
    check("min_slot_dac_rht", 32'(bus.dac_rht), 32'h9BDF);
    check("min_slot_vld", 32'(vld_cnt - vbase), 1);
    check("min_slot_frame_err", 32'(bus.frame_err), 0);
    send_slot(1'b1, 16'h0000, 32, 1'b0, txr, tr);

    // Reset in the middle of a left slot while SDout is driving ones.
    bus.adc_lft = 16'hFFFF; bus.adc_rht = 16'hFFFF;
    for (int k = 0; k < 6; k++) send_bit(1'b0, 1'b0, 1'b0);
    check("mid_sdout_before_rst", 32'(bus.SDout), 1);
    rst_n = 1'b0;
    #30;
    check("mid_rst_sdout", 32'(bus.SDout), 0);
    check("mid_rst_dac_lft", 32'(bus.dac_lft), 0);
    check("mid_rst_dac_rht", 32'(bus.dac_rht), 0);
    rst_n = 1'b1;
    vbase = vld_cnt;
    for (int k = 6; k < 32; k++) send_bit(1'b0, 1'b1, 1'b0);
    send_slot(1'b1, 16'h0F0F, 32, 1'b0, txr, tr);
    check("mid_rst_no_vld", 32'(vld_cnt - vbase), 0);
    send_slot(1'b0, 16'h5A5A, 32, 1'b0, txl, tl);
    send_slot(1'b1, 16'hC3C3, 32, 1'b0, txr, tr);
    check("relock_dac_lft", 32'(bus.dac_lft), 32'h5A5A);
    check("relock_dac_rht", 32'(bus.dac_rht), 32'hC3C3);
    check("relock_vld", 32'(vld_cnt - vbase), 1);

    // Short slot: LRCLK toggles after 8 data bits.
    vbase = vld_cnt;
    send_slot(1'b0, 16'hAAAA, 9, 1'b0, txl, tl);
    send_slot(1'b1, 16'h5555, 32, 1'b0, txr, tr);
    check("short_frame_err", 32'(bus.frame_err), 1);
    check("short_no_vld", 32'(vld_cnt - vbase), 0);
    check("short_dac_lft_held", 32'(bus.dac_lft), 32'h5A5A);
    send_slot(1'b0, 16'h2468, 32, 1'b0, txl, tl);
    send_slot(1'b1, 16'hACE0, 32, 1'b0, txr, tr);
    check("short_resume_dac_lft", 32'(bus.dac_lft), 32'h2468);
    check("short_resume_dac_rht", 32'(bus.dac_rht), 32'hACE0);
    check("short_resume_vld", 32'(vld_cnt - vbase), 1);
    check("short_err_sticky", 32'(bus.frame_err), 1);

    // Reset clears the sticky flag; an over-long slot sets it again.
    rst_n = 1'b0;
    #30;
    rst_n = 1'b1;
    check("rst_clears_err", 32'(bus.frame_err), 0);
    send_slot(1'b0, 16'h0000, 32, 1'b0, txl, tl);
    send_slot(1'b1, 16'h0000, 32, 1'b0, txr, tr);
    check("pre_long_frame_err", 32'(bus.frame_err), 0);
    vbase = vld_cnt;
    lbase = ld_cnt;
    send_slot(1'b0, 16'h1111, 33, 1'b0, txl, tl);
    check("long_frame_err", 32'(bus.frame_err), 1);
    check("long_ld_once", 32'(ld_cnt - lbase), 1);
    send_slot(1'b1, 16'h2222, 32, 1'b0, txr, tr);
    check("long_no_vld", 32'(vld_cnt - vbase), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
